pc_alu_ctrl: RTL and testbench
==============================

PC_ALU_CTRL -- requirements
Module: pc_alu_ctrl

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, default 32, datapath width of PC, operands and result.
REQ-002 SHALL have port: clk  input  1  single clock, rising-edge active.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: instr  input  32  current instruction word.
REQ-005 SHALL have port: RD1  input  DATA_WIDTH  register operand 1, drives ALUop1.
REQ-006 SHALL have port: RD2  input  DATA_WIDTH  register operand 2 (regOp2).
REQ-007 SHALL have port: ImmOp  input  DATA_WIDTH  sign-extended immediate from the extend unit.
REQ-008 SHALL have port: PC_out  output  DATA_WIDTH  current program counter.
REQ-009 SHALL have port: ALUout  output  DATA_WIDTH  ALU result, register write data.
REQ-010 SHALL have port: EQ  output  1  high when ALUout equals zero.
REQ-011 SHALL have port: RegWrite  output  1  register-file write enable.
REQ-012 SHALL have port: ImmSrc  output  2  immediate format select to extend unit.
REQ-013 SHALL have ports: ALUctrl (output, 3), ALUsrc (output, 1), PCsrc (output, 1), exposing internal control.

Function
REQ-014 Decode SHALL be purely combinational from instr[6:0], instr[14:12], instr[30] and EQ.
REQ-015 Opcode 0010011 (OP-IMM): RegWrite=1, ALUsrc=1, ImmSrc=00, PCsrc=0; funct3 000 ADDI->ALUctrl 000, 111 ANDI->010, 110 ORI->011, 010 SLTI->101; other funct3 ->000.
REQ-016 Opcode 0110011 (OP): RegWrite=1, ALUsrc=0, ImmSrc=00, PCsrc=0; funct3 000 with instr[30]=0 ->000 (ADD), instr[30]=1 ->001 (SUB); 111->010; 110->011; 010->101; other ->000.
REQ-017 Opcode 1100011 (BRANCH): RegWrite=0, ALUsrc=0, ImmSrc=10, ALUctrl=001; PCsrc = EQ for funct3 000 (BEQ), ~EQ for funct3 001 (BNE), 0 otherwise.
REQ-018 Any other opcode: RegWrite=0, PCsrc=0, ALUsrc=0, ImmSrc=00, ALUctrl=000.
REQ-019 ALU operand 2 SHALL be ImmOp when ALUsrc=1, else RD2.
REQ-020 ALUctrl 000 add, 001 sub, 010 and, 011 or, 101 signed set-less-than (result 1 or 0), others yield 0; add/sub wrap modulo 2^DATA_WIDTH.
REQ-021 EQ SHALL be 1 exactly when ALUout == 0, combinationally, regardless of opcode.
REQ-022 On each rising clk with rst low: PC_out <= PC_out + ImmOp if PCsrc=1, else PC_out + 4; both wrap modulo 2^DATA_WIDTH.
REQ-023 PC_out SHALL be the only state; all other outputs combinational with zero latency.

Reset
REQ-024 rst high SHALL force PC_out to 0 immediately, independent of clk, and hold it while asserted.
REQ-025 Reset asserted mid-branch SHALL win; first rising clk after deassertion SHALL apply REQ-022 from PC 0.

Configuration
REQ-026 With macro PC_TRACE_EN defined, each rising clk SHALL print "PC: <PC_out hex>, instr: <instr hex>, alu: <ALUout hex>" via simulation display; without it no display code SHALL exist and function SHALL be identical.

Verification
REQ-027 rst pulse mid-cycle with PC=0x10 -> PC_out=0 immediately; after release, 3 clocks of NOP (0x00000013) -> PC 4, 8, 0xC.
REQ-028 ADDI instr 0x00500513, RD1=0, ImmOp=5 -> ALUout=5, RegWrite=1, ALUsrc=1, EQ=0, PC +4.
REQ-029 BNE instr 0xFE0598E3, RD1=3, RD2=0, ImmOp=0xFFFFFFF0, PC=0x20 -> EQ=0, PCsrc=1, next PC=0x10, RegWrite=0.
REQ-030 BNE with RD1=RD2=7 -> EQ=1, PCsrc=0, next PC=PC+4; BEQ same operands -> PCsrc=1.
REQ-031 SUB RD1=0, RD2=1 -> ALUout=0xFFFFFFFF; SLT same -> ALUout=1; ADD 0xFFFFFFFF+1 -> ALUout=0, EQ=1.
REQ-032 Unknown opcode 0x0000007F -> RegWrite=0, PCsrc=0, next PC=PC+4; PC=0xFFFFFFFC -> wraps to 0.

Source files
------------

// File: rtl/pc_alu_ctrl.sv
// Single-cycle PC, ALU and RV32I-subset decode; optional per-clock trace print under `PC_TRACE_EN`.
// PC is the only register (updates every clock). All other outputs are combinational with zero latency. There is no backpressure.
module pc_alu_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr,
  input  logic [DATA_WIDTH-1:0] RD1,
  input  logic [DATA_WIDTH-1:0] RD2,
  input  logic [DATA_WIDTH-1:0] ImmOp,
  output logic [DATA_WIDTH-1:0] PC_out,
  output logic [DATA_WIDTH-1:0] ALUout,
  output logic                  EQ,
  output logic                  RegWrite,
  output logic [1:0]            ImmSrc,
  output logic [2:0]            ALUctrl,
  output logic                  ALUsrc,
  output logic                  PCsrc
);

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic                  is_beq;
  logic                  is_bne;
  logic [DATA_WIDTH-1:0] alu_op1;
  logic [DATA_WIDTH-1:0] alu_op2;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] pc_d;
  logic                  unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // Decode never looks at EQ; branch resolution is kept separate so there is no comb loop through the ALU.
  always_comb begin
    RegWrite = 1'b0;
    ALUsrc   = 1'b0;
    ImmSrc   = 2'b00;
    ALUctrl  = 3'b000;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    case (opcode)
      OPC_OPIMM: begin
        RegWrite = 1'b1;
        ALUsrc   = 1'b1;
        case (funct3)
          3'b111:  ALUctrl = 3'b010;
          3'b110:  ALUctrl = 3'b011;
          3'b010:  ALUctrl = 3'b101;
          default: ALUctrl = 3'b000;
        endcase
      end
      OPC_OP: begin
        RegWrite = 1'b1;
        case (funct3)
          3'b000:  ALUctrl = instr[30] ? 3'b001 : 3'b000;
          3'b111:  ALUctrl = 3'b010;
          3'b110:  ALUctrl = 3'b011;
          3'b010:  ALUctrl = 3'b101;
          default: ALUctrl = 3'b000;
        endcase
      end
      OPC_BRANCH: begin
        ImmSrc  = 2'b10;
        ALUctrl = 3'b001;
        is_beq  = (funct3 == 3'b000);
        is_bne  = (funct3 == 3'b001);
      end
      default: ;
    endcase
  end

  assign alu_op1 = RD1;
  assign alu_op2 = ALUsrc ? ImmOp : RD2;

  always_comb begin
    ALUout = '0;
    case (ALUctrl)
      3'b000:  ALUout = alu_op1 + alu_op2;
      3'b001:  ALUout = alu_op1 - alu_op2;
      3'b010:  ALUout = alu_op1 & alu_op2;
      3'b011:  ALUout = alu_op1 | alu_op2;
      3'b101:  ALUout = {{(DATA_WIDTH-1){1'b0}}, ($signed(alu_op1) < $signed(alu_op2))};
      default: ALUout = '0;
    endcase
  end

  assign EQ    = (ALUout == '0);
  assign PCsrc = (is_beq & EQ) | (is_bne & ~EQ);

  assign pc_d = PCsrc ? (pc_q + ImmOp) : (pc_q + DATA_WIDTH'(4));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PC_out = pc_q;

`ifdef PC_TRACE_EN
  always @(posedge clk) begin
    $display("PC: %h, instr: %h, alu: %h", PC_out, instr, ALUout);
  end
`else
`endif

endmodule

// File: tb/tb_pc_alu_ctrl.sv
// Directed and randomized checks of pc_alu_ctrl against an instruction-level reference model.
module tb_pc_alu_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [31:0] ImmOp;
  logic [31:0] PC_out;
  logic [31:0] ALUout;
  logic        EQ;
  logic        RegWrite;
  logic [1:0]  ImmSrc;
  logic [2:0]  ALUctrl;
  logic        ALUsrc;
  logic        PCsrc;

  pc_alu_ctrl #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .RD1(RD1), .RD2(RD2), .ImmOp(ImmOp),
    .PC_out(PC_out), .ALUout(ALUout), .EQ(EQ), .RegWrite(RegWrite),
    .ImmSrc(ImmSrc), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .PCsrc(PCsrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] pc_m;
  bit          taken_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: what each instruction means, then the resulting value and branch outcome.
  task automatic drive_check(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] imm);
    bit [6:0]  op;
    bit [2:0]  f3;
    bit        rw, src;
    bit [1:0]  isrc;
    bit [2:0]  ctl;
    bit [31:0] opnd2, res;
    instr = ins; RD1 = a; RD2 = b; ImmOp = imm;
    #1;
    op = ins[6:0]; f3 = ins[14:12];
    rw = 0; src = 0; isrc = 0; ctl = 0; taken_m = 0;
    if (op == 7'h13 || op == 7'h33) begin
      rw  = 1;
      src = (op == 7'h13);
      if (f3 == 3'd7) ctl = 3'd2;
      else if (f3 == 3'd6) ctl = 3'd3;
      else if (f3 == 3'd2) ctl = 3'd5;
      else if (f3 == 3'd0 && op == 7'h33 && ins[30]) ctl = 3'd1;
      else ctl = 3'd0;
    end else if (op == 7'h63) begin
      isrc = 2'b10;
      ctl  = 3'd1;
    end
    opnd2 = src ? imm : b;
    case (ctl)
      3'd0: res = a + opnd2;
      3'd1: res = a - opnd2;
      3'd2: res = a & opnd2;
      3'd3: res = a | opnd2;
      3'd5: res = (int'(a) < int'(opnd2)) ? 32'd1 : 32'd0;
      default: res = 32'd0;
    endcase
    if (op == 7'h63 && f3 == 3'd0) taken_m = (a == b);
    if (op == 7'h63 && f3 == 3'd1) taken_m = (a != b);
    check("ALUout",   ALUout,          res);
    check("EQ",       {31'd0, EQ},       {31'd0, res == 0});
    check("RegWrite", {31'd0, RegWrite}, {31'd0, rw});
    check("ALUsrc",   {31'd0, ALUsrc},   {31'd0, src});
    check("ImmSrc",   {30'd0, ImmSrc},   {30'd0, isrc});
    check("ALUctrl",  {29'd0, ALUctrl},  {29'd0, ctl});
    check("PCsrc",    {31'd0, PCsrc},    {31'd0, taken_m});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    pc_m = taken_m ? pc_m + ImmOp : pc_m + 32'd4;
    check("PC_next", PC_out, pc_m);
  endtask

  task automatic set_pc(input logic [31:0] target);
    drive_check(32'h0000_0063, 32'd0, 32'd0, target - pc_m);
    tick();
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    rst = 1'b1; instr = NOP; RD1 = 0; RD2 = 0; ImmOp = 0;
    pc_m = 0; taken_m = 0;
    #1;
    check("reset_pc", PC_out, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", PC_out, 32'd0);
    rst = 1'b0;

    // Advance to 0x10, then pulse reset mid-cycle
    repeat (4) begin drive_check(NOP, 0, 0, 0); tick(); end
    check("pc_at_10", PC_out, 32'h10);
    #2 rst = 1'b1;
    #1 check("rst_async", PC_out, 32'd0);
    #1 rst = 1'b0;
    pc_m = 0;
    for (int i = 1; i <= 3; i++) begin
      drive_check(NOP, 0, 0, 0);
      tick();
      check("nop_seq", PC_out, 32'(4 * i));
    end

    drive_check(32'h0050_0513, 32'd0, 32'd7, 32'd5);
    check("addi_res", ALUout, 32'd5);
    check("addi_rw",  {31'd0, RegWrite}, 32'd1);
    tick();

    set_pc(32'h20);
    drive_check(32'hFE05_98E3, 32'd3, 32'd0, 32'hFFFF_FFF0);
    check("bne_taken", {31'd0, PCsrc}, 32'd1);
    tick();
    check("bne_target", PC_out, 32'h10);

    drive_check(32'hFE05_98E3, 32'd7, 32'd7, 32'h40);
    check("bne_eq", {31'd0, EQ}, 32'd1);
    tick();
    check("bne_fall", PC_out, 32'h14);
    drive_check(32'hFE05_88E3, 32'd7, 32'd7, 32'h40);
    check("beq_taken", {31'd0, PCsrc}, 32'd1);
    tick();
    check("beq_target", PC_out, 32'h54);

    drive_check(32'h4000_0033, 32'd0, 32'd1, 32'd9);
    check("sub_neg", ALUout, 32'hFFFF_FFFF);
    tick();
    drive_check(32'h0000_2033, 32'd0, 32'd1, 32'd9);
    check("slt_one", ALUout, 32'd1);
    tick();
    drive_check(32'h0000_0033, 32'hFFFF_FFFF, 32'd1, 32'd9);
    check("add_wrap", ALUout, 32'd0);
    tick();

    drive_check(32'h0000_007F, 32'd3, 32'd3, 32'h100);
    tick();
    set_pc(32'hFFFF_FFFC);
    drive_check(32'h0000_007F, 32'd1, 32'd2, 32'h100);
    tick();
    check("pc_wrap", PC_out, 32'd0);

    // Reset arriving while a taken branch is pending must win
    set_pc(32'h80);
    drive_check(32'h0000_0063, 32'd5, 32'd5, 32'h40);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_vs_branch", PC_out, 32'd0);
    rst = 1'b0;
    pc_m = 0;
    tick();
    check("post_rst_branch", PC_out, 32'h40);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] ins, a, b, imm;
      int k;
      ins = $urandom;
      k = $urandom_range(0, 3);
      case (k)
        0: ins[6:0] = 7'h13;
        1: ins[6:0] = 7'h33;
        2: begin ins[6:0] = 7'h63; if ($urandom_range(0, 1) == 1) ins[14:12] = 3'($urandom_range(0, 1)); end
        default: ins[6:0] = 7'($urandom);
      endcase
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      imm = ($urandom_range(0, 3) == 0) ? -a : $urandom;
      drive_check(ins, a, b, imm);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
